// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. data-stage access with starvation guard.
// Three-state cycle (IDLE -> ACCESS -> DONE); read data registered, one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_starve_cnt
);

  // Handshake: a requester holds req (and its address/data) high until it
  // sees its ack; ack is a one-cycle pulse with read data valid in that cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [1:0]          starve_q, starve_d;
  logic                grant_f_q, grant_f_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                fetch_win;

  // Data has priority unless the pending fetch has been passed over STARVE_MAX times.
  assign fetch_win = if_req && (!dm_req || (starve_q == STARVE_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= 2'd0;
      grant_f_q  <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      grant_f_q  <= grant_f_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_f_d  = grant_f_q;
    addr_d     = addr_q;
    we_d       = we_q;
    din_d      = din_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d   = ACCESS;
          grant_f_d = fetch_win;
          if (fetch_win) begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            din_d    = '0;
            starve_d = 2'd0;
          end else begin
            addr_d = dm_addr;
            we_d   = dm_we;
            din_d  = dm_wdata;
            if (!if_req)
              starve_d = 2'd0;
            else if (starve_q != STARVE_LIM)
              starve_d = starve_q + 2'd1;
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        we_d    = 1'b0;
        // Memory presents read data at the mid-cycle falling edge.
        if (!we_q) begin
          if (grant_f_q) if_data_d  = mem_data_out;
          else           dm_rdata_d = mem_data_out;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_ack           = (state_q == DONE) && grant_f_q;
  assign dm_ack           = (state_q == DONE) && !grant_f_q;
  assign if_data          = if_data_q;
  assign dm_rdata         = dm_rdata_q;
  assign mem_address      = addr_q;
  assign mem_write_enable = we_q;
  assign mem_data_in      = din_q;
  assign busy             = (state_q != IDLE);
  assign dbg_state        = state_q;
  assign dbg_starve_cnt   = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 4096x16 memory, vector table of
// single transactions, plus directed reset / arbitration / starvation sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_ack;
  logic [15:0] if_data;
  logic        dm_req;
  logic        dm_we;
  logic [11:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic [11:0] mem_address;
  logic        mem_write_enable;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_starve_cnt;

  logic [15:0] mem [4096];

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_if = 16'h0000;
  logic [15:0] exp_dm = 16'h0000;

  typedef struct {
    logic        is_f;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write_enable) mem[mem_address] <= mem_data_in;

  always @(negedge clk)
    if (!mem_write_enable) mem_data_out <= mem[mem_address];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the DONE->IDLE edge.
  task automatic run_txn(input int idx, input logic is_f, input logic we,
                         input logic [11:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp);
    if (is_f) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy", idx), busy, 1);
    chk($sformatf("v%0d_addr", idx), mem_address, addr);
    chk($sformatf("v%0d_we", idx), mem_write_enable, is_f ? 1'b0 : we);
    chk($sformatf("v%0d_din", idx), mem_data_in, is_f ? 16'h0000 : wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_if_ack", idx), if_ack, is_f);
    chk($sformatf("v%0d_dm_ack", idx), dm_ack, !is_f);
    chk($sformatf("v%0d_we_clr", idx), mem_write_enable, 0);
    if (is_f) exp_if = exp;
    else if (!we) exp_dm = exp;
    chk($sformatf("v%0d_if_data", idx), if_data, exp_if);
    chk($sformatf("v%0d_dm_rdata", idx), dm_rdata, exp_dm);
    if (!is_f && we) chk($sformatf("v%0d_memwr", idx), mem[addr], wdata);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx), busy, 0);
    chk($sformatf("v%0d_acks_off", idx), {if_ack, dm_ack}, 0);
    chk($sformatf("v%0d_addr_hold", idx), mem_address, addr);
  endtask

  int exp_starve [5];
  int exp_is_f   [5];
  int ld_idx;

  initial begin
    mem[12'h005] = 16'h73FF;
    mem[12'h008] = 16'h0808;
    mem[12'h3FF] = 16'h5A5A;
    mem[12'hFFF] = 16'hC3C3;
    for (int i = 0; i < 4; i++) mem[12'h100 + i] = 16'h1100 + 16'(i);

    vecs[0] = '{1'b0, 1'b1, 12'h010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 12'h010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 12'h3FF, 16'h0000, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b1, 12'h3FF, 16'h0001, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 12'h3FF, 16'h0000, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hC3C3};
    vecs[6] = '{1'b0, 1'b1, 12'h000, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'hFFFF};

    // Reset held 2 cycles with both requests high
    reset = 1'b1; if_req = 1'b1; if_addr = 12'h005;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h008; dm_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {if_ack, dm_ack, mem_write_enable, busy}, 0);
    chk("rst_data", {if_data, dm_rdata}, 0);
    chk("rst_mem_side", {mem_address, mem_data_in}, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;

    // Simultaneous requests: data first (first edge after reset), fetch after
    @(posedge clk); #1;
    chk("sim_grant_d_addr", mem_address, 12'h008);
    chk("sim_starve1", dbg_starve_cnt, 1);
    @(posedge clk); #1;
    chk("sim_dm_ack", dm_ack, 1);
    chk("sim_if_ack0", if_ack, 0);
    chk("sim_dm_rdata", dm_rdata, 16'h0808);
    chk("sim_if_data0", if_data, 16'h0000);
    dm_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_gap_idle", busy, 0);
    @(posedge clk); #1;
    chk("sim_grant_f_addr", mem_address, 12'h005);
    chk("sim_starve0", dbg_starve_cnt, 0);
    @(posedge clk); #1;
    chk("sim_if_ack", if_ack, 1);
    chk("sim_dm_ack0", dm_ack, 0);
    chk("sim_if_data", if_data, 16'h73FF);
    chk("sim_dm_keep", dm_rdata, 16'h0808);
    if_req = 1'b0;
    exp_if = 16'h73FF; exp_dm = 16'h0808;
    @(posedge clk); #1;

    // Vector table of single transactions
    for (int i = 0; i < 8; i++)
      run_txn(i, vecs[i].is_f, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Starvation: fetch pending while data issues 4 back-to-back loads
    exp_starve = '{1, 2, 3, 0, 0};
    exp_is_f   = '{0, 0, 0, 1, 0};
    ld_idx = 0;
    if_req = 1'b1; if_addr = 12'h005;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h100; dm_wdata = 16'h0000;
    for (int r = 0; r < 5; r++) begin
      @(posedge clk); #1;
      chk($sformatf("stv%0d_busy", r), busy, 1);
      chk($sformatf("stv%0d_cnt", r), dbg_starve_cnt, exp_starve[r]);
      chk($sformatf("stv%0d_addr", r), mem_address,
          (exp_is_f[r] != 0) ? 12'h005 : 12'h100 + 12'(ld_idx));
      @(posedge clk); #1;
      chk($sformatf("stv%0d_if_ack", r), if_ack, (exp_is_f[r] != 0));
      chk($sformatf("stv%0d_dm_ack", r), dm_ack, (exp_is_f[r] == 0));
      if (exp_is_f[r] != 0) begin
        chk($sformatf("stv%0d_if_data", r), if_data, 16'h73FF);
        if_req = 1'b0;
      end else begin
        chk($sformatf("stv%0d_dm_rdata", r), dm_rdata, 16'h1100 + 16'(ld_idx));
        ld_idx++;
        if (ld_idx == 4) dm_req = 1'b0;
        else dm_addr = 12'h100 + 12'(ld_idx);
      end
      @(posedge clk); #1;
    end
    chk("stv_end_idle", busy, 0);

    // Reset during ACCESS of a store: write lands, no ack
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h020; dm_wdata = 16'h1234;
    @(posedge clk); #1;
    chk("rw_we_access", mem_write_enable, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rw_no_ack", dm_ack, 0);
    chk("rw_mem", mem[12'h020], 16'h1234);
    chk("rw_state", dbg_state, 0);
    chk("rw_outs", {mem_write_enable, busy, mem_address, dm_rdata}, 0);
    reset = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;

    // Reset during DONE cuts the ack and clears read data
    dm_req = 1'b1; dm_addr = 12'h010; dm_wdata = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd_ack", dm_ack, 1);
    chk("rd_rdata", dm_rdata, 16'hBEEF);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rd_ack_cut", dm_ack, 0);
    chk("rd_rdata_clr", dm_rdata, 0);
    reset = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port access controller between the CPU core and the 4096x16 program/data memory. It arbitrates instruction-fetch reads against data-stage loads, stores, pushes and pops, and drives the memory's address, write-enable and write-data inputs. It registers the memory's read data and returns it to the winning requester with a one-cycle acknowledge. The memory it drives writes on the clock rising edge when write-enable is high, and updates its read data on the falling edge when write-enable is low.

## Interface
Parameters:
- ADDR_W, 12: memory address width (4096 words).
- DATA_W, 16: word width.
- STARVE_MAX, 3: consecutive data grants allowed while a fetch is pending before the fetch is forced.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_data is valid in the same cycle.
- if_data  out  DATA_W  registered fetched word.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store/push, 0 = load/pop.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle pulse on completion (loads and stores).
- dm_rdata  out  DATA_W  registered load data.
- mem_address  out  ADDR_W  drives the memory address.
- mem_write_enable  out  1  drives the memory write enable.
- mem_data_in  out  DATA_W  drives the memory write data.
- mem_data_out  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: arbitrate; grant → ACCESS.
  - ACCESS: memory cycle; → DONE unconditionally.
  - DONE: ack pulse; → IDLE unconditionally; no requests are sampled in DONE.
- Arbitration in IDLE:
  - Data wins over fetch, unless starve_cnt == STARVE_MAX and if_req is high. In that case fetch wins.
  - starve_cnt is a 2-bit counter:
    - Increments on each data grant while if_req is high.
    - Clears on each fetch grant.
    - Clears on a data grant while if_req is low.
    - Saturates at STARVE_MAX.
- On grant, register the memory-side signals and latch the winner in a grant flag (F/D):
  - mem_address ← winner address.
  - mem_write_enable ← dm_we for a data grant, 0 for a fetch grant.
  - mem_data_in ← dm_wdata for a data grant, 0 for a fetch grant.
- ACCESS → DONE edge:
  - If mem_write_enable = 1, the memory writes at this edge.
  - Otherwise, mem_data_out (updated at the mid-cycle falling edge) is captured into if_data or dm_rdata according to the grant flag.
  - mem_write_enable clears to 0 at this same edge.
- Read data register of the non-winning port holds its value.
- On a data store, dm_rdata is unchanged.
- mem_address holds its last value outside ACCESS; only mem_write_enable matters to the memory.
- No address checking; 12-bit addresses cover the full array.

## Timing
- Reset values: state IDLE, starve_cnt 0, if_ack 0, dm_ack 0, if_data 0, dm_rdata 0, mem_address 0, mem_write_enable 0, mem_data_in 0, busy 0.
- Request sampled at rising edge P0 (state IDLE) → ACCESS from P0 to P1 → DONE from P1 to P2 with ack = 1 → IDLE at P2. The earliest next grant is at P3.
- Latency is 2 cycles from sampling edge to ack. Throughput is one access per 3 cycles.
- The requester may drop req at P2, at the edge ending the ack cycle; the DONE → IDLE gap makes this safe.
- Simultaneous if_req and dm_req with starve_cnt < STARVE_MAX: data is served first. Fetch is granted at the next IDLE if the data port is idle or starve_cnt has reached STARVE_MAX.
- Reset asserted during ACCESS with mem_write_enable = 1: the memory write at that edge still completes, because the memory has no reset. No ack is issued, and all outputs take their reset values.
- Reset asserted during DONE: the ack is cut; outputs return to reset values at that edge.
- A request that drops before being granted is ignored; no ack is issued.

## Test plan
- Reset: hold reset 2 cycles with if_req = dm_req = 1 → all outputs 0 and busy 0. The first grant occurs at the first edge after reset deasserts.
- Fetch: memory[5] = 16'h73FF; if_req = 1, if_addr = 5 sampled at P0 → mem_write_enable 0 throughout; if_ack = 1 and if_data = 16'h73FF during P1–P2; dm_ack stays 0.
- Store then load: dm_we = 1, dm_addr = 12'h010, dm_wdata = 16'hBEEF → mem_write_enable = 1 only during ACCESS; dm_ack pulses once. Then a load from 12'h010 → dm_rdata = 16'hBEEF.
- Simultaneous requests: if_req and dm_req both rise before P0 (load from 8) → dm_ack at P1–P2, then if_ack at P4–P5; if_data is unaffected by the data access.
- Starvation: if_req held high while the data port issues 4 back-to-back loads → order is D, D, D, F, D; starve_cnt goes 1, 2, 3, 0.
- Reset mid-write: assert reset during ACCESS of a store of 16'h1234 to 12'h020 → no dm_ack; memory[12'h020] = 16'h1234 afterwards; state IDLE.
